// File: rtl/pingpong_mod_ctrl_pkg.sv
// Shared types and constants for the modulation-mapper ping-pong buffer controller.
package mod_buf_pkg;

    // Life cycle of one buffer bank.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_t;

    localparam int MEM_DEPTH_C  = 1200;
    localparam int ADDR_WIDTH_C = 11;

    // A bank holding a closed block (waiting or being read) cannot be written.
    function automatic logic is_pending(input bank_state_t s);
        return (s == FULL) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/pingpong_mod_ctrl_if.sv
// Mapper-side and downstream-side signals of the ping-pong buffer controller.
interface pingpong_mod_ctrl_if
    import mod_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_C
);
    logic                  mod_valid;
    logic                  mod_done;
    logic                  rd_ready;
    logic                  busy;
    logic                  wr_en;
    logic                  wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_en;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic                  rd_last;
    logic [1:0]            blocks_pending;
    logic                  overflow;

    // Environment side: mapper and downstream stage.
    modport master (
        output mod_valid, mod_done, rd_ready,
        input  busy, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
        input  rd_valid, rd_last, blocks_pending, overflow
    );

    // Controller side.
    modport slave (
        input  mod_valid, mod_done, rd_ready,
        output busy, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
        output rd_valid, rd_last, blocks_pending, overflow
    );
endinterface

// File: rtl/pingpong_mod_ctrl_bank_state.sv
// State and block length of a single ping-pong bank.
module pp_bank_state
    import mod_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_C
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  first_wr,
    input  logic                  close,
    input  logic [ADDR_WIDTH-1:0] close_len,
    input  logic                  start_drain,
    input  logic                  release_bank,
    output bank_state_t           state,
    output bank_state_t           state_next,
    output logic [ADDR_WIDTH-1:0] len
);
    bank_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;

    // Next bank state; a close wins over a first write so a one-symbol block goes straight to FULL.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            EMPTY: begin
                if (close) begin
                    state_d = FULL;
                    len_d   = close_len;
                end else if (first_wr) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (close) begin
                    state_d = FULL;
                    len_d   = close_len;
                end
            end
            FULL: begin
                if (start_drain) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (release_bank) begin
                    state_d = EMPTY;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                len_d   = '0;
            end
        endcase
    end

    // Bank state and length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    assign state      = state_q;
    assign state_next = state_d;
    assign len        = len_q;

endmodule

// File: rtl/pingpong_mod_ctrl.sv
// Ping-pong symbol buffer sequencer: write/read pointers, bank selects and RAM strobes.
module pingpong_mod_ctrl
    import mod_buf_pkg::*;
#(
    parameter int MEM_DEPTH  = MEM_DEPTH_C,
    parameter int ADDR_WIDTH = ADDR_WIDTH_C
)(
    input  logic                CLK,
    input  logic                RST,
    pingpong_mod_ctrl_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    bank_state_t           bank_state      [2];
    bank_state_t           bank_state_next [2];
    logic [ADDR_WIDTH-1:0] bank_len        [2];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            blocks_pending_q, blocks_pending_d;

    logic                  busy;
    logic                  wr_en;
    logic                  rd_en;
    logic                  close_blk;
    logic                  rd_done;
    logic [ADDR_WIDTH-1:0] eff_len;
    logic [ADDR_WIDTH-1:0] cur_len;

    // One state/length holder per bank; the top decides which bank each event targets.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank_state #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk          (CLK),
            .rst_n        (RST),
            .first_wr     (wr_en && (wr_sel_q == 1'(b))),
            .close        (close_blk && (wr_sel_q == 1'(b))),
            .close_len    (eff_len),
            .start_drain  ((rd_sel_q == 1'(b)) && (bank_state[b] == FULL)),
            .release_bank (rd_done && (rd_sel_q == 1'(b))),
            .state        (bank_state[b]),
            .state_next   (bank_state_next[b]),
            .len          (bank_len[b])
        );
    end

    // Write-side strobes and block close; the final symbol of a block may share its cycle with mod_done.
    always_comb begin
        busy      = is_pending(bank_state[wr_sel_q]);
        wr_en     = bus.mod_valid && !busy && (wr_ptr_q < DEPTH_A);
        eff_len   = wr_ptr_q + ADDR_WIDTH'(wr_en);
        close_blk = bus.mod_done && !busy && (eff_len != '0);
        wr_ptr_d  = wr_ptr_q;
        if (close_blk) begin
            wr_ptr_d = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE_A;
        end
        wr_sel_d   = wr_sel_q ^ close_blk;
        overflow_d = overflow_q || (bus.mod_valid && !busy && (wr_ptr_q == DEPTH_A));
    end

    // Read-side strobes; a bank released here becomes writable only from the next cycle on.
    always_comb begin
        cur_len  = bank_len[rd_sel_q];
        rd_en    = (bank_state[rd_sel_q] == DRAIN) && bus.rd_ready;
        rd_done  = rd_en && (rd_ptr_q == (cur_len - ONE_A));
        rd_ptr_d = rd_ptr_q;
        if (rd_done) begin
            rd_ptr_d = '0;
        end else if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ONE_A;
        end
        rd_sel_d         = rd_sel_q ^ rd_done;
        rd_valid_d       = rd_en;
        rd_last_d        = rd_done;
        blocks_pending_d = {1'b0, is_pending(bank_state_next[0])}
                         + {1'b0, is_pending(bank_state_next[1])};
    end

    // Pointers, selects and registered status outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            wr_sel_q         <= 1'b0;
            rd_sel_q         <= 1'b0;
            rd_valid_q       <= 1'b0;
            rd_last_q        <= 1'b0;
            overflow_q       <= 1'b0;
            blocks_pending_q <= 2'd0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_sel_q         <= wr_sel_d;
            rd_sel_q         <= rd_sel_d;
            rd_valid_q       <= rd_valid_d;
            rd_last_q        <= rd_last_d;
            overflow_q       <= overflow_d;
            blocks_pending_q <= blocks_pending_d;
        end
    end

    assign bus.busy           = busy;
    assign bus.wr_en          = wr_en;
    assign bus.wr_bank        = wr_sel_q;
    assign bus.wr_addr        = wr_ptr_q;
    assign bus.rd_en          = rd_en;
    assign bus.rd_bank        = rd_sel_q;
    assign bus.rd_addr        = rd_ptr_q;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_last        = rd_last_q;
    assign bus.blocks_pending = blocks_pending_q;
    assign bus.overflow       = overflow_q;

endmodule

// File: doc/pingpong_mod_ctrl.md
Name: pingpong_mod_ctrl

Overview:
- Sequencing controller for the modulation-mapper ping-pong symbol buffer (two banks, MEM_DEPTH entries each).
- Owns bank state, write/read addressing, per-bank block length, bank swapping and mapper backpressure.
- The buffer itself is a plain dual-bank RAM driven only by this block's strobes; mapper upstream, resource/DFT stage downstream.

Parameters:
- MEM_DEPTH, 1200, entries per bank (max symbols per block).
- ADDR_WIDTH, 11, address/length width; must satisfy 2^ADDR_WIDTH > MEM_DEPTH.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  asynchronous, active-low reset.
- mod_valid  in  1  mapper symbol valid this cycle.
- mod_done  in  1  one-cycle pulse marking the end of the current block; may coincide with the block's final mod_valid.
- rd_ready  in  1  downstream accepts one symbol this cycle.
- busy  out  1  stall to mapper: the write bank is not writable.
- wr_en  out  1  RAM write strobe.
- wr_bank  out  1  bank written (0=ping, 1=pong).
- wr_addr  out  ADDR_WIDTH  0-based write address.
- rd_en  out  1  RAM read strobe (synchronous RAM, 1-cycle read latency).
- rd_bank  out  1  bank read.
- rd_addr  out  ADDR_WIDTH  0-based read address.
- rd_valid  out  1  RAM data valid (rd_en delayed 1 cycle).
- rd_last  out  1  aligned with rd_valid; last symbol of the block.
- blocks_pending  out  2  banks in FULL or DRAIN (0..2).
- overflow  out  1  sticky: a symbol arrived with the write bank already holding MEM_DEPTH symbols.

Behaviour:
- Per-bank state: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY. Each bank holds a length register len[b].
- Reset: both banks EMPTY, len=0, wr_sel=rd_sel=0, wr_ptr=rd_ptr=0. All outputs 0 except busy=0.
- Write side (combinational strobes):
  - Target bank is wr_sel. busy = (state[wr_sel] is FULL or DRAIN).
  - wr_en = mod_valid & !busy & (wr_ptr < MEM_DEPTH); wr_addr = wr_ptr; wr_bank = wr_sel.
  - An EMPTY bank moves to FILL on its first accepted write.
  - Each wr_en increments wr_ptr at the next edge.
  - mod_valid with wr_ptr == MEM_DEPTH: no write, overflow set (cleared only by reset). mod_valid while busy: the mapper must hold; no write occurs.
- mod_done handling:
  - Effective length L = wr_ptr + wr_en.
  - L > 0: next edge len[wr_sel] <= L, state FULL, wr_sel toggles, wr_ptr <= 0.
  - L == 0: pulse ignored, no state change.
  - mod_done while busy: ignored.
- Read side:
  - rd_sel bank in FULL: moves to DRAIN next edge; the first rd_en is possible in the cycle after that (2 cycles from FULL entry).
  - In DRAIN: rd_en = rd_ready; rd_addr = rd_ptr; rd_bank = rd_sel.
  - Each rd_en increments rd_ptr.
  - rd_en with rd_ptr == len[rd_sel]-1: next edge the bank goes EMPTY, rd_sel toggles, rd_ptr <= 0; rd_last asserts with the matching rd_valid.
  - rd_valid and rd_last are registers (1-cycle latency from rd_en).
- Simultaneous events:
  - A bank freed by the read side in cycle N is writable in N+1 (busy drops in N+1). Same-cycle reuse is not allowed.
  - Write to one bank and read from the other in the same cycle are always allowed.
  - mod_done and the final mod_valid in the same cycle: that symbol is included in L.
- Wrap: wr_sel and rd_sel are 1-bit and alternate strictly, so blocks leave the buffer in arrival order.
- blocks_pending: registered count of banks in FULL/DRAIN.
- Reset mid-operation discards all blocks; no rd_valid follows reset.

Decomposition:
- Shared package mod_buf_pkg:
  - bank_state_t enum {EMPTY, FILL, FULL, DRAIN}.
  - MEM_DEPTH_C=1200, ADDR_WIDTH_C=11.
- Sub-module pp_bank_state, instantiated twice: holds state and len for one bank; inputs are first_wr, close(L), start_drain, release.
- Pointers, selects and output strobes stay in the top level.

Test Plan:
- Single block: 5 mod_valid with mod_done on the 5th, rd_ready=1 -> wr_addr 0..4 on bank 0; rd_addr 0..4 on bank 0; rd_valid x5 with rd_last on the 5th; blocks_pending 1->0.
- Back-to-back with rd_ready=0: block of 3, then block of 4, then a third mod_valid -> the second block is written to bank 1, busy=1 on the third symbol, blocks_pending=2. Raise rd_ready -> bank 0 drains 3 symbols; busy drops the cycle after bank 0's release; the third symbol is written to bank 0 addr 0.
- Full depth: 1200 symbols with done on the last, then 1 extra symbol before done -> len=1200 accepted; the extra symbol on the next block is normal. A separate case sends 1201 symbols without done -> overflow=1, no wr_en for the 1201st.
- Empty done: mod_done with no symbols -> no state change, wr_sel stays 0, blocks_pending 0.
- Read throttling: block of 4, rd_ready pattern 1,0,1,0,1,1 -> rd_addr 0,1,2,3 issued only on ready cycles; rd_last on the 4th rd_valid.
- Async reset asserted mid-drain of bank 0 with bank 1 FULL -> all outputs 0, blocks_pending 0; no rd_valid after reset release until a new block completes.
